// File: rtl/ext_pkg.sv
// Shared types and constants for the operand extender: mode codes, lane sizes,
// skid-buffer states and the byte-offset width helper.
package ext_pkg;

    typedef enum logic [2:0] {
        OP_ZEXT = 3'd0,
        OP_SEXT = 3'd1,
        OP_LUI  = 3'd2,
        OP_LBU  = 3'd3,
        OP_LB   = 3'd4,
        OP_LHU  = 3'd5,
        OP_LH   = 3'd6,
        OP_LW   = 3'd7
    } ext_op_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / LANE_W);
    endfunction

endpackage

// File: rtl/ext_if.sv
// Valid/ready bundle between a producer stage and the operand extender.
interface ext_if #(
    parameter int DATA_W = 32
);
    import ext_pkg::*;

    localparam int OFF_W = off_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_data, in_off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ext_core.sv
// Combinational extension datapath: immediate forms, little-endian lane
// selection for loads, and misalignment detection. Misaligned results are zero.
module ext_core
    import ext_pkg::*;
#(
    parameter int   DATA_W = 32,
    parameter int   IMM_W  = 16,
    localparam int  OFF_W  = off_w(DATA_W)
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] lui_val;
    logic [LANE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    assign imm    = data[IMM_W-1:0];
    assign byte_v = data[{off, 3'b000} +: LANE_W];
    assign half_v = data[{off[OFF_W-1:1], 4'b0000} +: HALF_W];

    // When the shifted immediate already fills the word, no sign fill is needed.
    generate
        if (2 * IMM_W >= DATA_W) begin : g_lui_wide
            assign lui_val = DATA_W'({imm, {IMM_W{1'b0}}});
        end else begin : g_lui_narrow
            assign lui_val = {{(DATA_W - 2 * IMM_W){imm[IMM_W-1]}}, imm, {IMM_W{1'b0}}};
        end
    endgenerate

    always_comb begin
        err    = 1'b0;
        result = '0;
        case (ext_op_e'(op))
            OP_ZEXT: result = {{(DATA_W - IMM_W){1'b0}}, imm};
            OP_SEXT: result = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
            OP_LUI:  result = lui_val;
            OP_LBU:  result = {{(DATA_W - LANE_W){1'b0}}, byte_v};
            OP_LB:   result = {{(DATA_W - LANE_W){byte_v[LANE_W-1]}}, byte_v};
            OP_LHU: begin
                if (off[0]) err = 1'b1;
                else        result = {{(DATA_W - HALF_W){1'b0}}, half_v};
            end
            OP_LH: begin
                if (off[0]) err = 1'b1;
                else        result = {{(DATA_W - HALF_W){half_v[HALF_W-1]}}, half_v};
            end
            OP_LW: begin
                if (off != '0) err = 1'b1;
                else           result = data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_unit.sv
// Registered operand extender: ext_core on the input side feeding a main
// register plus one skid register, so in_ready never depends on out_ready.
module ext_unit
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    ext_if.slave  bus
);

    logic              core_err;
    logic [DATA_W-1:0] core_data;

    skid_state_e       state;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_data;
    logic              main_err;
    logic [DATA_W-1:0] skid_data;
    logic              skid_err;

    logic accept;
    logic emit;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .op     (bus.in_op),
        .data   (bus.in_data),
        .off    (bus.in_off),
        .err    (core_err),
        .result (core_data)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign emit   = out_valid_q && bus.out_ready;

    // The skid state drives the registered valid/ready outputs; flush only
    // clears occupancy, so an emit on the flush edge has already been taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SKID_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data   <= '0;
            main_err    <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else if (flush) begin
            state       <= SKID_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_data   <= core_data;
                        main_err    <= core_err;
                        out_valid_q <= 1'b1;
                        state       <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && !emit) begin
                        skid_data  <= core_data;
                        skid_err   <= core_err;
                        in_ready_q <= 1'b0;
                        state      <= SKID_TWO;
                    end else if (accept && emit) begin
                        main_data <= core_data;
                        main_err  <= core_err;
                    end else if (emit) begin
                        out_valid_q <= 1'b0;
                        state       <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (emit) begin
                        main_data  <= skid_data;
                        main_err   <= skid_err;
                        in_ready_q <= 1'b1;
                        state      <= SKID_ONE;
                    end
                end
                default: begin
                    state       <= SKID_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data;
    assign bus.out_err   = main_err;

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: directed mode vectors, random beats against
// an arithmetic reference model, backpressure streaming, flush and reset.
module tb_ext_unit;
    import ext_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;

    int errors;
    int checks;

    ext_if #(.DATA_W(32)) bus32 ();
    ext_if #(.DATA_W(64)) bus64 ();

    ext_unit #(.DATA_W(32), .IMM_W(16)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus32)
    );

    ext_unit #(.DATA_W(64), .IMM_W(16)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {err, data} for the 32-bit unit, from plain arithmetic.
    function automatic logic [32:0] ref_ext(input int op, input logic [31:0] d, input int off);
        longint dd, imm, b, h, v;
        bit     err;
        dd = 0;
        dd[31:0] = d;
        imm = dd % 65536;
        b   = (dd >> (8 * off)) % 256;
        h   = (dd >> (8 * off)) % 65536;
        v   = 0;
        err = 1'b0;
        case (op)
            0: v = imm;
            1: v = (imm >= 32768) ? imm - 65536 : imm;
            2: v = imm * 65536;
            3: v = b;
            4: v = (b >= 128) ? b - 256 : b;
            5: if (off % 2 != 0) err = 1'b1; else v = h;
            6: if (off % 2 != 0) err = 1'b1; else v = (h >= 32768) ? h - 65536 : h;
            7: if (off != 0) err = 1'b1; else v = dd;
            default: v = 0;
        endcase
        if (err) v = 0;
        return {err, v[31:0]};
    endfunction

    task automatic drive_one(input logic [2:0] op, input logic [31:0] d, input logic [1:0] off,
                             output logic ov, output logic [31:0] od, output logic oe);
        @(negedge clk);
        bus32.in_valid  = 1'b1;
        bus32.in_op     = op;
        bus32.in_data   = d;
        bus32.in_off    = off;
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        ov = bus32.out_valid;
        od = bus32.out_data;
        oe = bus32.out_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus32.out_valid); end
        checks++;
        if (bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus32.in_ready); end
        checks++;
        if (bus32.out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", bus32.out_data); end
        checks++;
        if (bus32.out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", bus32.out_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_imm();
        logic ov, oe;
        logic [31:0] od;
        drive_one(OP_SEXT, 32'h0000_8001, 2'd0, ov, od, oe);
        checks++;
        if ({ov, oe, od} !== {1'b1, 1'b0, 32'hFFFF_8001}) begin errors++; $display("[TB] FAIL sext: got v=%b e=%b d=%h expected v=1 e=0 d=ffff8001", ov, oe, od); end
        drive_one(OP_ZEXT, 32'h0000_8001, 2'd0, ov, od, oe);
        checks++;
        if ({ov, oe, od} !== {1'b1, 1'b0, 32'h0000_8001}) begin errors++; $display("[TB] FAIL zext: got v=%b e=%b d=%h expected v=1 e=0 d=00008001", ov, oe, od); end
        drive_one(OP_LUI, 32'h0000_1234, 2'd3, ov, od, oe);
        checks++;
        if ({ov, oe, od} !== {1'b1, 1'b0, 32'h1234_0000}) begin errors++; $display("[TB] FAIL lui32: got v=%b e=%b d=%h expected v=1 e=0 d=12340000", ov, oe, od); end
    endtask

    task automatic test_lui64();
        @(negedge clk);
        bus64.in_valid  = 1'b1;
        bus64.in_op     = OP_LUI;
        bus64.in_data   = 64'h8000;
        bus64.in_off    = 3'd0;
        bus64.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus64.out_valid, bus64.out_err, bus64.out_data} !== {1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000}) begin
            errors++;
            $display("[TB] FAIL lui64: got v=%b e=%b d=%h expected v=1 e=0 d=ffffffff80000000", bus64.out_valid, bus64.out_err, bus64.out_data);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [7] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LH, OP_LW};
        logic [1:0]  offs [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
        logic [31:0] exps [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01, 32'h0, 32'h0};
        logic        errs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic ov, oe;
        logic [31:0] od;
        for (int i = 0; i < 7; i++) begin
            drive_one(ops[i], 32'h80FF_7F01, offs[i], ov, od, oe);
            checks++;
            if ({ov, oe, od} !== {1'b1, errs[i], exps[i]}) begin
                errors++;
                $display("[TB] FAIL load_%0d op=%0d off=%0d: got v=%b e=%b d=%h expected v=1 e=%b d=%h", i, ops[i], offs[i], ov, oe, od, errs[i], exps[i]);
            end
        end
    endtask

    task automatic test_random_single();
        logic ov, oe;
        logic [31:0] od, d;
        logic [32:0] exp;
        int op, off;
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 7);
            off = $urandom_range(0, 3);
            d   = $urandom;
            exp = ref_ext(op, d, off);
            drive_one(3'(op), d, 2'(off), ov, od, oe);
            checks++;
            if ({ov, oe, od} !== {1'b1, exp}) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%0d off=%0d d=%h: got v=%b e=%b d=%h expected e=%b d=%h", i, op, off, d, ov, oe, od, exp[32], exp[31:0]);
            end
        end
    endtask

    // Streams n beats with random out_ready; rnd selects random ops vs. ZEXT 1..n.
    task automatic test_back_to_back(input bit rnd, input int n);
        logic [32:0] q[$];
        logic [32:0] exp;
        logic [31:0] held_d, cur_d;
        logic held_e, have_held, prev_chk, acc_prev, r;
        int sent, got, cur_op, cur_off;
        sent = 0; got = 0;
        have_held = 1'b0; prev_chk = 1'b0; acc_prev = 1'b0;
        held_d = '0; held_e = 1'b0; cur_d = '0; cur_op = 0; cur_off = 0;
        bus32.in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < n; cyc++) begin
            @(negedge clk);
            if (have_held) begin
                checks++;
                if (bus32.out_data !== held_d || bus32.out_err !== held_e) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got e=%b d=%h expected e=%b d=%h", bus32.out_err, bus32.out_data, held_e, held_d);
                end
            end
            if (prev_chk) begin
                checks++;
                if (bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL in_ready_low_2cyc: got %b expected 1", bus32.in_ready); end
            end
            r = 1'($urandom_range(0, 1));
            bus32.out_ready = r;
            if (bus32.out_valid === 1'b1 && r) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stream_extra: got d=%h expected no beat", bus32.out_data);
                end else begin
                    exp = q.pop_front();
                    if ({bus32.out_err, bus32.out_data} !== exp) begin
                        errors++;
                        $display("[TB] FAIL stream_beat_%0d: got e=%b d=%h expected e=%b d=%h", got, bus32.out_err, bus32.out_data, exp[32], exp[31:0]);
                    end
                end
                got++;
            end
            have_held = (bus32.out_valid === 1'b1) && !r;
            held_d = bus32.out_data;
            held_e = bus32.out_err;
            prev_chk = (bus32.in_ready === 1'b0) && r;
            if (acc_prev) bus32.in_valid = 1'b0;
            if (!bus32.in_valid && sent < n) begin
                cur_op  = rnd ? $urandom_range(0, 7) : 0;
                cur_off = rnd ? $urandom_range(0, 3) : 0;
                cur_d   = rnd ? $urandom : 32'(sent + 1);
                bus32.in_valid = 1'b1;
                bus32.in_op    = 3'(cur_op);
                bus32.in_data  = cur_d;
                bus32.in_off   = 2'(cur_off);
            end
            acc_prev = bus32.in_valid && (bus32.in_ready === 1'b1);
            if (acc_prev) begin
                q.push_back(ref_ext(cur_op, cur_d, cur_off));
                sent++;
            end
        end
        checks++;
        if (got != n) begin errors++; $display("[TB] FAIL stream_count: got %0d beats expected %0d", got, n); end
        @(negedge clk);
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flush();
        logic ov, oe, seen;
        logic [31:0] od;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_op     = OP_ZEXT;
        bus32.in_off    = 2'd0;
        bus32.in_data   = 32'h11;
        @(negedge clk);
        bus32.in_data = 32'h22;
        @(negedge clk);
        checks++;
        if ({bus32.in_ready, bus32.out_valid, bus32.out_data} !== {1'b0, 1'b1, 32'h11}) begin
            errors++;
            $display("[TB] FAIL skid_full: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=00000011", bus32.in_ready, bus32.out_valid, bus32.out_data);
        end
        bus32.in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush_two: got v=%b rdy=%b expected v=0 rdy=1", bus32.out_valid, bus32.in_ready);
        end
        bus32.in_valid = 1'b1;
        bus32.in_data  = 32'h33;
        @(negedge clk);
        checks++;
        if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush_accept: got v=%b rdy=%b expected v=0 rdy=1", bus32.out_valid, bus32.in_ready);
        end
        flush = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus32.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL flush_discard: got out_valid=1 after flush expected 0"); end
        drive_one(OP_ZEXT, 32'h44, 2'd0, ov, od, oe);
        checks++;
        if ({ov, oe, od} !== {1'b1, 1'b0, 32'h44}) begin
            errors++;
            $display("[TB] FAIL post_flush: got v=%b e=%b d=%h expected v=1 e=0 d=00000044", ov, oe, od);
        end
    endtask

    task automatic test_reset_mid();
        logic ov, oe;
        logic [31:0] od;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_op     = OP_SEXT;
        bus32.in_off    = 2'd0;
        bus32.in_data   = 32'hABCD;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        checks++;
        if (bus32.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", bus32.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus32.out_valid, bus32.in_ready, bus32.out_data} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b rdy=%b d=%h expected v=0 rdy=1 d=0", bus32.out_valid, bus32.in_ready, bus32.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_one(OP_SEXT, 32'h0000_7FFF, 2'd0, ov, od, oe);
        checks++;
        if ({ov, oe, od} !== {1'b1, 1'b0, 32'h0000_7FFF}) begin
            errors++;
            $display("[TB] FAIL post_reset: got v=%b e=%b d=%h expected v=1 e=0 d=00007fff", ov, oe, od);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        flush  = 1'b0;
        rst_n  = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_op = '0; bus32.in_data = '0; bus32.in_off = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_op = '0; bus64.in_data = '0; bus64.in_off = '0; bus64.out_ready = 1'b1;
        test_reset();
        test_imm();
        test_lui64();
        test_loads();
        test_random_single();
        test_back_to_back(1'b0, 10);
        test_back_to_back(1'b1, 60);
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_unit.md
# ext_unit

Parametrised, registered operand extender for the CPU datapath. It replaces the single-mode immediate extender and serves both the ID stage (zero/sign/LUI immediates) and the MEM/WB stage (byte/halfword/word load-data alignment and extension). A valid/ready handshake with a two-entry skid buffer lets stalls propagate without a combinational ready path. A synchronous flush discards in-flight results on branch or exception.

## Interface
- DATA_W, 32: datapath width; 32 or 64.
- IMM_W, 16: immediate field width; must be less than DATA_W.
- OFF_W, $clog2(DATA_W/8): byte-offset width; derived, not overridden.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  input beat present
- in_ready  out  1  unit can accept a beat; driven from a register
- in_op  in  3  extension mode (see Operation)
- in_data  in  DATA_W  immediate (low IMM_W bits used) or raw memory word
- in_off  in  OFF_W  byte address offset; load modes only
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  extended result
- out_err  out  1  misaligned access; out_data is 0 when set

## Operation
- Modes, with imm = in_data[IMM_W-1:0]:
  - 0 ZEXT: imm zero-extended.
  - 1 SEXT: imm sign-extended.
  - 2 LUI: imm shifted left by IMM_W, then sign-extended from bit 2*IMM_W-1 (identity when DATA_W = 2*IMM_W).
  - 3 LBU / 4 LB: byte at lane in_off, zero- or sign-extended.
  - 5 LHU / 6 LH: halfword at lane in_off[OFF_W-1:1], zero- or sign-extended.
  - 7 LW: full word.
- Immediate modes 0–2 ignore in_off and never raise out_err.
- Misalignment: LH/LHU with in_off[0]=1, or LW with in_off≠0, sets out_err=1 with out_data=0.
- Every mode is defined, so no X ever reaches out_data.
- Byte lanes are little-endian: lane k is in_data[8k+7:8k].
- Buffering is a main register plus one skid register.
  - Accept on in_valid && in_ready.
  - Emit on out_valid && out_ready.
- Skid register states: EMPTY, ONE (main only), TWO (main + skid).
  - EMPTY, accept → ONE.
  - ONE: accept without emit → TWO. Accept with emit → ONE (main reloaded). Emit only → EMPTY.
  - TWO: emit moves skid into main → ONE. No accept is possible in TWO.
- in_ready = !skid_valid, registered.
- Ordering is strictly FIFO; no beat is dropped or duplicated except by flush.

## Timing
- Reset values (async, rst_n low): out_valid=0, out_data=0, out_err=0, in_ready=1, internal valids=0.
- Latency: accepted beat appears on out_valid the next cycle when the buffer was EMPTY.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_ready low with in_valid high fills the skid one cycle later, and in_ready drops the cycle after. The beat offered on the cycle ready was still high is captured, not lost.
- out_data and out_err are held stable while out_valid && !out_ready.
- flush: both valids cleared at the next edge and in_ready=1 after it. A beat accepted in the flush cycle is discarded. An emit in the flush cycle still completes.
- Reset asserted mid-transfer clears everything immediately. The first acceptance is on the first edge after rst_n rises.

## Structure
- Package ext_pkg holds:
  - the enum ext_op_e with the eight mode codes;
  - localparams for lane width (8) and half width (16);
  - the function off_w(DATA_W).
- Sub-module ext_core: purely combinational mode/lane/extension logic and misalignment detect, producing {err, data}.
- ext_unit instantiates ext_core on the input side and registers its result in the skid pipeline.

## Test plan
- Reset, then SEXT in_data=0x0000_8001 → out_data=0xFFFF_8001, out_err=0, one cycle after accept. ZEXT with the same data → 0x0000_8001.
- LUI in_data=0x1234 → 0x1234_0000. With DATA_W=64 and in_data=0x8000 → 0xFFFF_FFFF_8000_0000.
- in_data=0x80FF_7F01:
  - LB off=3 → 0xFFFF_FF80; LBU off=3 → 0x0000_0080.
  - LH off=2 → 0xFFFF_80FF; LHU off=0 → 0x0000_7F01.
  - LW off=0 → 0x80FF_7F01.
- Misalignment: LH off=1 and LW off=2 → out_err=1, out_data=0.
- Backpressure: stream beats 1..10 with out_ready toggling pseudo-randomly. Required: outputs exactly 1..10 in order, in_ready never low for more than one cycle while out_ready is high, and held data stable during stalls.
- Flush with two entries held (skid full): next cycle out_valid=0 and in_ready=1, and a beat accepted in the flush cycle never emerges. Reset asserted mid-stream: out_valid=0 immediately.
